counter_strobe_driver: RTL

- Upstream driver for counter_with_strobe.
- Accepts raw tick events and period-change requests from the system side. Issues single-cycle enable pulses to the counter only when its ready is high.
- Owns the counter's reset_value and changes it only on a legal cycle (strobe high, enable low).
- Buffers bursts of ticks in a saturating pending count, so the downstream counter's inter-enable latency never drops events silently.

---
 rtl/counter_strobe_driver_pkg.sv | 6 +
 rtl/sat_updown_counter.sv | 31 +++
 rtl/counter_strobe_driver.sv | 81 ++++++++
 3 files changed

// File: rtl/counter_strobe_driver_pkg.sv
// counter_strobe_driver_pkg: shared state encoding and constants for counter_strobe_driver.
package counter_strobe_driver_pkg;
  typedef enum logic [1:0] {S_WAIT = 2'd0, S_PULSE = 2'd1, S_GAP = 2'd2} state_e;
  localparam int MIN_PERIOD = 2;
  localparam int STROBE_COUNT_W = 16;
endpackage

// File: rtl/sat_updown_counter.sv
// sat_updown_counter: saturating up/down counter with a sticky flag set when an increment is lost at the top.
module sat_updown_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             sat_hit
);
  localparam logic [WIDTH-1:0] MAX = '1;
  logic [WIDTH-1:0] count_q, count_d;
  logic             sat_hit_q, sat_hit_d;
  always_comb begin
    count_d   = (inc && !dec && count_q != MAX) ? count_q + WIDTH'(1) :
                (dec && !inc && count_q != '0) ? count_q - WIDTH'(1) : count_q;
    sat_hit_d = sat_hit_q || (inc && !dec && count_q == MAX);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      sat_hit_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      sat_hit_q <= sat_hit_d;
    end
  end
  assign count   = count_q;
  assign sat_hit = sat_hit_q;
endmodule

// File: rtl/counter_strobe_driver.sv
// counter_strobe_driver: queues ticks into single-cycle enables and applies period changes on legal strobe cycles.
// Define STROBE_COUNT_EN to enable the 16-bit strobe_count of valid strobes; otherwise strobe_count is 0.
module counter_strobe_driver
  import counter_strobe_driver_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int PEND_WIDTH   = 4,
  parameter int RESET_PERIOD = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick_in,
  input  logic [WIDTH-1:0]          period_in,
  input  logic                      period_load,
  input  logic                      cnt_ready,
  input  logic                      cnt_strobe,
  input  logic                      cnt_valid,
  output logic                      enable,
  output logic [WIDTH-1:0]          reset_value,
  output logic                      period_busy,
  output logic [PEND_WIDTH-1:0]     pending,
  output logic                      overflow,
  output logic [STROBE_COUNT_W-1:0] strobe_count
);
  localparam logic [WIDTH-1:0] MIN_P = WIDTH'(MIN_PERIOD);
  state_e           state_q, state_d;
  logic             enable_q, enable_d;
  logic [WIDTH-1:0] reset_value_q, reset_value_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             busy_q, busy_d;
  logic             issue, apply;
  sat_updown_counter #(.WIDTH(PEND_WIDTH)) u_pend (
    .clk     (clk),
    .rst     (rst),
    .inc     (tick_in),
    .dec     (issue),
    .count   (pending),
    .sat_hit (overflow)
  );
  always_comb begin
    issue         = state_q == S_WAIT && pending != '0 && cnt_ready;
    apply         = busy_q && cnt_strobe && !enable_q;
    state_d       = state_q == S_WAIT ? (issue ? S_PULSE : S_WAIT) :
                    state_q == S_PULSE ? S_GAP : S_WAIT;
    enable_d      = issue;
    shadow_d      = period_load ? (period_in < MIN_P ? MIN_P : period_in) : shadow_q;
    busy_d        = period_load || (busy_q && !apply);
    reset_value_d = apply ? shadow_q : reset_value_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_GAP;
      enable_q      <= 1'b0;
      reset_value_q <= WIDTH'(RESET_PERIOD);
      shadow_q      <= WIDTH'(RESET_PERIOD);
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      enable_q      <= enable_d;
      reset_value_q <= reset_value_d;
      shadow_q      <= shadow_d;
      busy_q        <= busy_d;
    end
  end
  assign enable      = enable_q;
  assign reset_value = reset_value_q;
  assign period_busy = busy_q;
`ifdef STROBE_COUNT_EN
  logic [STROBE_COUNT_W-1:0] strobe_count_q, strobe_count_d;
  always_comb strobe_count_d = strobe_count_q + STROBE_COUNT_W'(cnt_strobe && cnt_valid);
  always_ff @(posedge clk) begin
    if (rst) strobe_count_q <= '0;
    else     strobe_count_q <= strobe_count_d;
  end
  assign strobe_count = strobe_count_q;
`else
  logic unused_valid;
  assign unused_valid = cnt_valid;
  assign strobe_count = '0;
`endif
endmodule
